// File: rtl/gpio_ctrl.sv
// Parametrised GPIO bank: per-pin direction/output registers, atomic set/clear/toggle,
// synchronised inputs with edge detection, sticky W1C status and a maskable level irq.
module gpio_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] RESET_OUT   = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire  [WIDTH-1:0]  pin,
  input  logic              valid,
  input  logic              we,
  input  logic [3:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              irq
);

  localparam int unsigned WarmMax = SYNC_STAGES + 1;

  logic [WIDTH-1:0] dir_q, dir_d, out_q, out_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d, irq_rise_q, irq_rise_d, irq_fall_q, irq_fall_d;
  logic [WIDTH-1:0] irq_stat_q, irq_stat_d, prev_q, prev_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [2:0]       warm_q, warm_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d, irq_q, irq_d;

  logic             wr, rd, edge_en;
  logic [WIDTH-1:0] wmask, in_w, rise_w, fall_w, stat_set, stat_clr;
  logic [31:0]      rd_word;

  assign wr    = valid & we;
  assign rd    = valid & ~we;
  assign wmask = wdata[WIDTH-1:0];
  assign in_w  = sync_q[SYNC_STAGES-1];

  // Upper write-data bits have no backing storage when WIDTH < 32.
  logic unused_wdata;
  if (WIDTH < 32) begin : g_unused
    assign unused_wdata = ^wdata[31:WIDTH];
  end else begin : g_full
    assign unused_wdata = 1'b0;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign pin[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  always_comb begin
    dir_d      = dir_q;
    out_d      = out_q;
    irq_en_d   = irq_en_q;
    irq_rise_d = irq_rise_q;
    irq_fall_d = irq_fall_q;
    stat_clr   = '0;
    if (wr) begin
      case (addr)
        4'd0:    dir_d      = wmask;
        4'd1:    out_d      = wmask;
        4'd2:    out_d      = out_q | wmask;
        4'd3:    out_d      = out_q & ~wmask;
        4'd4:    out_d      = out_q ^ wmask;
        4'd6:    irq_en_d   = wmask;
        4'd7:    irq_rise_d = wmask;
        4'd8:    irq_fall_d = wmask;
        4'd9:    stat_clr   = wmask;
        default: ;
      endcase
    end
  end

  // Edges are ignored until the synchroniser and prev register hold real pin data.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], pin};
    prev_d     = in_w;
    warm_d     = (warm_q == 3'(WarmMax)) ? warm_q : warm_q + 3'd1;
    edge_en    = (warm_q == 3'(WarmMax));
    rise_w     = in_w & ~prev_q;
    fall_w     = ~in_w & prev_q;
    stat_set   = edge_en ? ((rise_w & irq_rise_q) | (fall_w & irq_fall_q)) : '0;
    irq_stat_d = (irq_stat_q & ~stat_clr) | stat_set;
    irq_d      = |(irq_stat_q & irq_en_q);
  end

  always_comb begin
    rd_word = '0;
    case (addr)
      4'd0:    rd_word[WIDTH-1:0] = dir_q;
      4'd1:    rd_word[WIDTH-1:0] = out_q;
      4'd5:    rd_word[WIDTH-1:0] = in_w;
      4'd6:    rd_word[WIDTH-1:0] = irq_en_q;
      4'd7:    rd_word[WIDTH-1:0] = irq_rise_q;
      4'd8:    rd_word[WIDTH-1:0] = irq_fall_q;
      4'd9:    rd_word[WIDTH-1:0] = irq_stat_q;
      default: ;
    endcase
    rdata_d  = rd ? rd_word : rdata_q;
    rvalid_d = rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q      <= '0;
      out_q      <= RESET_OUT[WIDTH-1:0];
      irq_en_q   <= '0;
      irq_rise_q <= '0;
      irq_fall_q <= '0;
      irq_stat_q <= '0;
      prev_q     <= '0;
      sync_q     <= '0;
      warm_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      out_q      <= out_d;
      irq_en_q   <= irq_en_d;
      irq_rise_q <= irq_rise_d;
      irq_fall_q <= irq_fall_d;
      irq_stat_q <= irq_stat_d;
      prev_q     <= prev_d;
      sync_q     <= sync_d;
      warm_q     <= warm_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      irq_q      <= irq_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = irq_q;

endmodule
